// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_t     - scanner FSM states (SCAN, DEBOUNCE, PRESSED)
//   key_code_t  - 4-bit key code, row_idx*4 + col_idx
//   COL_RESET   - column drive after reset (column 0 active, active-low)
//   ROWS_IDLE   - synchronized row value with no contact
//   lowest_low_row() - index of the lowest-numbered row that reads low
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    typedef logic [3:0] key_code_t;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROWS_IDLE = 4'hF;

    // Priority pick: when several rows are low, the lowest index wins.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd3;
        if (!rows[2]) idx = 2'd2;
        if (!rows[1]) idx = 2'd1;
        if (!rows[0]) idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchronizer for the 4 keypad row inputs.
// Resets to all-ones so an idle (pulled-up) keypad is seen while in reset.
//   clk - system clock
//   rst - asynchronous active-low reset
//   d   - raw asynchronous rows
//   q   - synchronized rows
module keypad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 4'hF;
            r_sync <= 4'hF;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with single-key debounce and a
// valid/ready key-code output.
//
// Optional build macro: KEYPAD_REPEAT_EN enables auto-repeat while a key
// stays down (first repeat after REPEAT_DELAY ticks, then every REPEAT_RATE
// ticks). Without it, each debounced press yields exactly one event.
//
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   row       - keypad rows, active-low, asynchronous
//   col       - column drive, one-hot active-low
//   key_code  - row_idx*4 + col_idx of the pending event
//   key_valid - event pending
//   key_ready - consumer ready
//   key_held  - a debounced key is currently down
//   key_drop  - sticky: an event was lost because one was still pending
//   dbg_state - current scanner FSM state (state_t encoding)
//
// Handshake: an event transfers on any clock edge where key_valid and
// key_ready are both high. While key_valid is high and key_ready is low,
// key_code and key_valid hold; key_valid never drops without a transfer.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       key_drop,
    output logic [1:0] dbg_state
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

    // Out-of-range configurations elaborate this visibly named empty scope.
    if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_out_of_range
    end

    // ------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------
    logic [3:0] w_row_s;

    keypad_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (w_row_s)
    );

    // ------------------------------------------------------------------
    // Scan-tick prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] r_pcnt;
    logic          w_tick;

    assign w_tick = (r_pcnt == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scanner FSM
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_next;
    logic [1:0]    r_col_idx;
    logic [1:0]    w_col_idx_next;
    logic [1:0]    r_row_idx;
    logic [1:0]    w_row_idx_next;
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_next;
    logic [DW-1:0] w_dcnt_inc;
    logic [DW-1:0] r_rcnt;
    logic [DW-1:0] w_rcnt_next;
    logic [DW-1:0] w_rcnt_inc;
    logic          w_row_bit;
    logic          w_emit;

    // Only the latched row matters once a key is being tracked.
    assign w_row_bit = w_row_s[r_row_idx];

    // Saturating increments
    assign w_dcnt_inc = (r_dcnt == DW'(DEBOUNCE_TICKS)) ? r_dcnt : r_dcnt + 1'b1;
    assign w_rcnt_inc = (r_rcnt == DW'(DEBOUNCE_TICKS)) ? r_rcnt : r_rcnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= SCAN;
            r_col_idx <= 2'd0;
            r_row_idx <= 2'd0;
            r_dcnt    <= '0;
            r_rcnt    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_col_idx <= w_col_idx_next;
            r_row_idx <= w_row_idx_next;
            r_dcnt    <= w_dcnt_next;
            r_rcnt    <= w_rcnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_col_idx_next = r_col_idx;
        w_row_idx_next = r_row_idx;
        w_dcnt_next    = r_dcnt;
        w_rcnt_next    = r_rcnt;
        w_emit         = 1'b0;

        case (r_state)
            SCAN: begin
                if (w_tick) begin
                    if (w_row_s != ROWS_IDLE) begin
                        // Column stays frozen; r_col_idx already names it.
                        w_row_idx_next = lowest_low_row(w_row_s);
                        w_dcnt_next    = DW'(1);
                        w_state_next   = DEBOUNCE;
                    end else begin
                        w_col_idx_next = r_col_idx + 2'd1;
                    end
                end
            end

            DEBOUNCE: begin
                if (w_tick) begin
                    if (!w_row_bit) begin
                        w_dcnt_next = w_dcnt_inc;
                        if (w_dcnt_inc == DW'(DEBOUNCE_TICKS)) begin
                            w_emit       = 1'b1;
                            w_rcnt_next  = '0;
                            w_state_next = PRESSED;
                        end
                    end else begin
                        // Bounce: resume walking from the next column.
                        w_state_next   = SCAN;
                        w_col_idx_next = r_col_idx + 2'd1;
                    end
                end
            end

            PRESSED: begin
                if (w_tick) begin
                    if (w_row_bit) begin
                        w_rcnt_next = w_rcnt_inc;
                        // Same column is rescanned first after release.
                        if (w_rcnt_inc == DW'(DEBOUNCE_TICKS)) begin
                            w_state_next = SCAN;
                        end
                    end else begin
                        w_rcnt_next = '0;
                    end
                end
            end

            default: begin
                w_state_next = SCAN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Auto-repeat
    // ------------------------------------------------------------------
    logic w_event;

`ifdef KEYPAD_REPEAT_EN
    localparam int KMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int KW   = $clog2(KMAX + 1);

    logic [KW-1:0] r_kcnt;
    logic [KW-1:0] w_kcnt_next;
    logic [KW-1:0] w_kcnt_inc;
    logic [KW-1:0] w_kcnt_target;
    logic          r_rep;
    logic          w_rep_next;
    logic          w_rep_emit;

    assign w_kcnt_inc    = r_kcnt + 1'b1;
    // After the first repeat, the interval switches to the repeat rate.
    assign w_kcnt_target = r_rep ? KW'(REPEAT_RATE) : KW'(REPEAT_DELAY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kcnt <= '0;
            r_rep  <= 1'b0;
        end else begin
            r_kcnt <= w_kcnt_next;
            r_rep  <= w_rep_next;
        end
    end

    always_comb begin
        w_kcnt_next = r_kcnt;
        w_rep_next  = r_rep;
        w_rep_emit  = 1'b0;
        if (r_state != PRESSED) begin
            w_kcnt_next = '0;
            w_rep_next  = 1'b0;
        end else if (w_tick) begin
            if (w_row_bit) begin
                // Any sampled release restarts the repeat timing.
                w_kcnt_next = '0;
                w_rep_next  = 1'b0;
            end else if (w_kcnt_inc == w_kcnt_target) begin
                w_rep_emit  = 1'b1;
                w_kcnt_next = '0;
                w_rep_next  = 1'b1;
            end else begin
                w_kcnt_next = w_kcnt_inc;
            end
        end
    end

    assign w_event = w_emit | w_rep_emit;
`else
    assign w_event = w_emit;
`endif

    // ------------------------------------------------------------------
    // Event holding register
    // ------------------------------------------------------------------
    key_code_t r_key_code;
    logic      r_key_valid;
    logic      r_key_drop;
    key_code_t w_event_code;

    assign w_event_code = {r_row_idx, r_col_idx};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_drop  <= 1'b0;
        end else if (w_event) begin
            // A slot frees up if the pending event transfers this same edge.
            if (!r_key_valid || key_ready) begin
                r_key_code  <= w_event_code;
                r_key_valid <= 1'b1;
            end else begin
                r_key_drop <= 1'b1;
            end
        end else if (r_key_valid && key_ready) begin
            r_key_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        case (r_col_idx)
            2'd0:    col = COL_RESET;
            2'd1:    col = 4'b1101;
            2'd2:    col = 4'b1011;
            default: col = 4'b0111;
        endcase
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_drop  = r_key_drop;
    assign key_held  = (r_state == PRESSED);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: self-checking bench for keypad_scan.
// A behavioural keypad (one pressed key pulls its row low while its column
// is driven) feeds the DUT; expected key codes are queued when presses are
// issued and a negedge monitor pops and compares on every transfer.
// Build with +define+KEYPAD_REPEAT_EN to include the auto-repeat scenario.
module tb_keypad_scan;
    import keypad_pkg::*;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int REPEAT_DELAY   = 5;
    localparam int REPEAT_RATE    = 2;

    localparam int REL_LO = (DEBOUNCE_TICKS - 1) * SCAN_DIV + 3;
    localparam int REL_HI = DEBOUNCE_TICKS * SCAN_DIV + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       key_held;
    logic       key_drop;
    logic [1:0] dbg_state;

    int pressed_key = -1;
    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .key_drop  (key_drop),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- keypad model ----------------
    always_comb begin
        row = 4'hF;
        if (pressed_key >= 0 && col[pressed_key % 4] == 1'b0)
            row[pressed_key / 4] = 1'b0;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_held(input logic lvl, input string name, output int n);
        n = 0;
        while (key_held !== lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(key_held), int'(lvl));
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [3:0] hold_code;
    bit         hold_pending = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending && key_valid)
                check("code_stable_while_stalled", key_code, hold_code);
            hold_pending = key_valid && !key_ready;
            hold_code    = key_code;
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got code %0d, none expected", key_code);
                end else begin
                    check("event_code", key_code, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int         n;
        int         k;
        int         h;
        int         g;
        int         last_i;
        int         changes;
        bit         saw;
        logic [3:0] prev_col;
        logic [3:0] rot;
        int         got_t[$];
        int         exp_t[$];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col", col, 4'b1110);
        check("rst_key_code", key_code, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_held", key_held, 0);
        check("rst_key_drop", key_drop, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b1;

        // Idle column walk
        prev_col = col;
        last_i   = -1;
        changes  = 0;
        saw      = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (key_valid || key_held) saw = 1'b1;
            if (col != prev_col) begin
                rot = {prev_col[2:0], prev_col[3]};
                check("idle_col_order", col, rot);
                if (last_i >= 0) check("idle_col_period", i - last_i, SCAN_DIV);
                last_i   = i;
                changes++;
                prev_col = col;
            end
        end
        check("idle_col_changes", changes, 24 / SCAN_DIV);
        check("idle_no_activity", saw, 0);

        // Steady press of row 2 / col 1
        pressed_key = 9;
        exp_q.push_back(4'd9);
        wait_held(1'b1, "press9_held_rise", n);
        repeat (3 * SCAN_DIV) @(negedge clk);
        check("press9_held_steady", key_held, 1);
        check("press9_event_seen", exp_q.size(), 0);
        pressed_key = -1;
        wait_held(1'b0, "press9_held_fall", n);
        check_range("press9_release_latency", n, REL_LO, REL_HI);
        check("press9_col_frozen", col, 4'b1101);
        n = 0;
        while (col == 4'b1101 && n < 3 * SCAN_DIV) begin
            @(negedge clk);
            n++;
        end
        check("press9_col_resume", col, 4'b1011);

        // Bouncing contact: low one tick, high one tick
        saw      = 1'b0;
        changes  = 0;
        prev_col = col;
        for (int j = 0; j < 10 * SCAN_DIV; j++) begin
            pressed_key = ((j / SCAN_DIV) % 2 == 0) ? 0 : -1;
            @(negedge clk);
            if (key_held || key_valid) saw = 1'b1;
            if (col != prev_col) begin
                changes++;
                prev_col = col;
            end
        end
        pressed_key = -1;
        check("bounce_no_event", saw, 0);
        check("bounce_col_walks", int'(changes >= 5), 1);
        repeat (2 * SCAN_DIV) @(negedge clk);

        // Randomized presses
        for (int it = 0; it < 8; it++) begin
            k = $urandom_range(0, 15);
            h = $urandom_range(0, 2);
            g = $urandom_range(1, 5);
            pressed_key = k;
            exp_q.push_back(4'(k));
            wait_held(1'b1, "rand_held_rise", n);
            repeat (h * SCAN_DIV) @(negedge clk);
            pressed_key = -1;
            wait_held(1'b0, "rand_held_fall", n);
            check_range("rand_release_latency", n, REL_LO, REL_HI);
            repeat (g * SCAN_DIV) @(negedge clk);
        end

        // Back-pressure: second event is dropped
        @(posedge clk);
        #1 key_ready = 1'b0;
        @(negedge clk);
        pressed_key = 0;
        exp_q.push_back(4'd0);
        wait_held(1'b1, "drop_key0_rise", n);
        pressed_key = -1;
        wait_held(1'b0, "drop_key0_fall", n);
        pressed_key = 5;
        wait_held(1'b1, "drop_key5_rise", n);
        pressed_key = -1;
        wait_held(1'b0, "drop_key5_fall", n);
        check("drop_code_kept", key_code, 0);
        check("drop_valid_kept", key_valid, 1);
        check("drop_flag", key_drop, 1);
        @(posedge clk);
        #1 key_ready = 1'b1;
        @(posedge clk);
        #1 check("drop_valid_cleared", key_valid, 0);
        check("drop_flag_sticky", key_drop, 1);

        // Reset during DEBOUNCE
        @(negedge clk);
        pressed_key = 4;
        n = 0;
        while (dbg_state != 2'(DEBOUNCE) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_reached_debounce", dbg_state, 2'(DEBOUNCE));
        rst = 1'b0;
        #1;
        check("rstmid_col", col, 4'b1110);
        check("rstmid_valid", key_valid, 0);
        check("rstmid_held", key_held, 0);
        check("rstmid_drop", key_drop, 0);
        check("rstmid_code", key_code, 0);
        check("rstmid_state", dbg_state, 2'(SCAN));
        repeat (2) @(negedge clk);
        exp_q.push_back(4'd4);
        rst = 1'b1;
        n = 0;
        while (!key_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_fresh_debounce_cycles", n, DEBOUNCE_TICKS * SCAN_DIV);
        @(negedge clk);
        pressed_key = -1;
        wait_held(1'b0, "rstmid_held_fall", n);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat while key 15 stays down for 12 ticks after acceptance
        repeat (2 * SCAN_DIV) @(negedge clk);
        for (int t = REPEAT_DELAY; t <= 12; t += REPEAT_RATE)
            exp_t.push_back(t * SCAN_DIV);
        for (int e = 0; e <= exp_t.size(); e++)
            exp_q.push_back(4'd15);
        pressed_key = 15;
        wait_held(1'b1, "repeat_held_rise", n);
        for (int i = 1; i <= 12 * SCAN_DIV; i++) begin
            @(negedge clk);
            if (key_valid) got_t.push_back(i);
        end
        pressed_key = -1;
        check("repeat_count", got_t.size(), exp_t.size());
        for (int e = 0; e < exp_t.size(); e++) begin
            if (e < got_t.size()) check("repeat_time", got_t[e], exp_t[e]);
        end
        wait_held(1'b0, "repeat_held_fall", n);
`endif

        repeat (4 * SCAN_DIV) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
